// File: rtl/dcache_line_engine_pkg.sv
// Shared types and sizing helpers for the D-cache line engine.
// ADDR_WIDTH/DATA_WIDTH match the values of the shared CPU configuration macros.
package dcache_line_engine_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int LINE_WORDS_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        WB_PUSH,
        WB_GO,
        WB_WAIT,
        RD_GO,
        RD_STREAM,
        FINISH
    } state_t;

    function automatic int line_bytes(input int line_words);
        return line_words * 4;
    endfunction

    function automatic int idx_w(input int line_words);
        return $clog2(line_words);
    endfunction

endpackage

// File: rtl/dcache_line_engine_ifc.sv
// Burst write / burst read request interfaces toward the SDRAM model/controller.
interface mem_write_ifc;
    import dcache_line_engine_pkg::*;

    logic                  control_go;
    logic [ADDR_WIDTH-1:0] control_base;
    logic [ADDR_WIDTH-1:0] control_length;
    logic                  control_done;
    logic                  user_we;
    logic [DATA_WIDTH-1:0] user_data;
    logic                  user_full;

    modport request (
        output control_go, control_base, control_length, user_we, user_data,
        input  control_done, user_full
    );
    modport responder (
        input  control_go, control_base, control_length, user_we, user_data,
        output control_done, user_full
    );
endinterface

interface mem_read_ifc;
    import dcache_line_engine_pkg::*;

    logic                  control_go;
    logic [ADDR_WIDTH-1:0] control_base;
    logic [ADDR_WIDTH-1:0] control_length;
    logic                  control_done;
    logic                  user_re;
    logic [DATA_WIDTH-1:0] user_data;
    logic                  user_available;

    modport request (
        output control_go, control_base, control_length, user_re,
        input  control_done, user_data, user_available
    );
    modport responder (
        input  control_go, control_base, control_length, user_re,
        output control_done, user_data, user_available
    );
endinterface

// File: rtl/dcache_line_engine_wb_hold_reg.sv
// One-entry holding register between the array read port and the write FIFO.
// Accepts a new word whenever it is empty or its current word leaves this cycle.
module wb_hold_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid;
    logic [W-1:0] data;

    assign in_ready  = !valid || out_ready;
    assign out_valid = valid;
    assign out_data  = data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (in_ready) begin
            valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            data <= in_data;
        end
    end

endmodule

// File: rtl/dcache_line_engine.sv
// Line-miss engine: optional victim writeback burst followed by optional refill burst,
// streaming words between the cache data array and the SDRAM FIFOs.
module dcache_line_engine
    import dcache_line_engine_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_wb,
    input  logic                          req_fill,
    input  logic [ADDR_WIDTH-1:0]         req_wb_addr,
    input  logic [ADDR_WIDTH-1:0]         req_fill_addr,
    output logic [$clog2(LINE_WORDS)-1:0] wb_rd_index,
    input  logic [DATA_WIDTH-1:0]         wb_rd_data,
    output logic                          fill_we,
    output logic [$clog2(LINE_WORDS)-1:0] fill_index,
    output logic [DATA_WIDTH-1:0]         fill_data,
    output logic                          done,
    mem_write_ifc.request                 mem_write,
    mem_read_ifc.request                  mem_read
);

    localparam int IDX_W = idx_w(LINE_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0]      FULL_CNT   = CNT_W'(LINE_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LINE_LEN   = ADDR_WIDTH'(line_bytes(LINE_WORDS));
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(line_bytes(LINE_WORDS) - 1));

    state_t state, state_next;

    logic                  do_fill;
    logic [ADDR_WIDTH-1:0] wb_addr, fill_addr;
    logic [ADDR_WIDTH-1:0] wb_addr_next, fill_addr_next;
    logic                  accept;

    logic                  rd_vld;
    logic [CNT_W-1:0]      acc_cnt, push_cnt, fill_cnt;
    logic [CNT_W-1:0]      idx_full, push_total, fill_total;
    logic                  hold_in_ready, hold_valid;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  rd_accept, push, rd_take;
    logic                  after_go;

    logic                  wgo, rgo;
    logic [ADDR_WIDTH-1:0] wbase, wlen, rbase, rlen;

    assign accept         = (state == IDLE) && req_valid;
    assign wb_addr_next   = accept ? (req_wb_addr & ALIGN_MASK) : wb_addr;
    assign fill_addr_next = accept ? (req_fill_addr & ALIGN_MASK) : fill_addr;

    // The index advances only when the word now arriving from the array is
    // taken; otherwise the same index is re-presented so the word comes back.
    assign rd_accept  = rd_vld && hold_in_ready;
    assign idx_full   = acc_cnt + CNT_W'(rd_accept);
    assign push       = hold_valid && !mem_write.user_full;
    assign push_total = push_cnt + CNT_W'(push);
    assign rd_take    = (state == RD_STREAM) && mem_read.user_available && (fill_cnt != FULL_CNT);
    assign fill_total = fill_cnt + CNT_W'(rd_take);

    wb_hold_reg #(.W(DATA_WIDTH)) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_vld),
        .in_ready  (hold_in_ready),
        .in_data   (wb_rd_data),
        .out_valid (hold_valid),
        .out_ready (!mem_write.user_full),
        .out_data  (hold_data)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_wb)        state_next = WB_PUSH;
                    else if (req_fill) state_next = RD_GO;
                    else               state_next = FINISH;
                end
            end
            WB_PUSH:   if (push_total == FULL_CNT) state_next = WB_GO;
            WB_GO:     state_next = WB_WAIT;
            // control_done right after go still reflects the previous burst
            WB_WAIT:   if (!after_go && mem_write.control_done) state_next = do_fill ? RD_GO : FINISH;
            RD_GO:     state_next = RD_STREAM;
            RD_STREAM: if (!after_go && mem_read.control_done && (fill_total == FULL_CNT)) state_next = FINISH;
            FINISH:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            do_fill  <= 1'b0;
            rd_vld   <= 1'b0;
            acc_cnt  <= '0;
            push_cnt <= '0;
            fill_cnt <= '0;
            after_go <= 1'b0;
            wgo      <= 1'b0;
            rgo      <= 1'b0;
            wbase    <= '0;
            wlen     <= '0;
            rbase    <= '0;
            rlen     <= '0;
        end else begin
            state    <= state_next;
            if (accept) do_fill <= req_fill;
            if (state == IDLE)         rd_vld <= accept && req_wb;
            else if (state == WB_PUSH) rd_vld <= (idx_full != FULL_CNT);
            else                       rd_vld <= 1'b0;
            acc_cnt  <= (state == WB_PUSH)   ? idx_full   : '0;
            push_cnt <= (state == WB_PUSH)   ? push_total : '0;
            fill_cnt <= (state == RD_STREAM) ? fill_total : '0;
            after_go <= (state == WB_GO) || (state == RD_GO);
            wgo      <= (state_next == WB_GO);
            rgo      <= (state_next == RD_GO);
            wbase    <= (state_next == WB_GO || state_next == WB_WAIT)   ? wb_addr        : '0;
            wlen     <= (state_next == WB_GO || state_next == WB_WAIT)   ? LINE_LEN       : '0;
            rbase    <= (state_next == RD_GO || state_next == RD_STREAM) ? fill_addr_next : '0;
            rlen     <= (state_next == RD_GO || state_next == RD_STREAM) ? LINE_LEN       : '0;
        end
    end

    always_ff @(posedge clk) begin
        wb_addr   <= wb_addr_next;
        fill_addr <= fill_addr_next;
    end

    assign req_ready   = (state == IDLE);
    assign done        = (state == FINISH);
    assign wb_rd_index = (state == WB_PUSH) ? idx_full[IDX_W-1:0] : '0;

    assign mem_write.control_go     = wgo;
    assign mem_write.control_base   = wbase;
    assign mem_write.control_length = wlen;
    assign mem_write.user_we        = push;
    assign mem_write.user_data      = hold_data;

    assign mem_read.control_go     = rgo;
    assign mem_read.control_base   = rbase;
    assign mem_read.control_length = rlen;
    assign mem_read.user_re        = rd_take;

    assign fill_we    = rd_take;
    assign fill_index = fill_cnt[IDX_W-1:0];
    assign fill_data  = mem_read.user_data;

endmodule

// File: tb/tb_dcache_line_engine.sv
// Scoreboard bench for dcache_line_engine with a small array model and SDRAM responders.
module tb_dcache_line_engine;
    import dcache_line_engine_pkg::*;

    localparam int LW = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  req_valid = 1'b0, req_wb = 1'b0, req_fill = 1'b0;
    logic [ADDR_WIDTH-1:0] req_wb_addr = '0, req_fill_addr = '0;
    logic [1:0]            wb_rd_index, fill_index;
    logic [DATA_WIDTH-1:0] wb_rd_data, fill_data;
    logic                  req_ready, fill_we, done;

    mem_write_ifc mem_write();
    mem_read_ifc  mem_read();

    dcache_line_engine #(.LINE_WORDS(LW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wb        (req_wb),
        .req_fill      (req_fill),
        .req_wb_addr   (req_wb_addr),
        .req_fill_addr (req_fill_addr),
        .wb_rd_index   (wb_rd_index),
        .wb_rd_data    (wb_rd_data),
        .fill_we       (fill_we),
        .fill_index    (fill_index),
        .fill_data     (fill_data),
        .done          (done),
        .mem_write     (mem_write),
        .mem_read      (mem_read)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endfunction

    // Cache data array: one-cycle read latency.
    logic [31:0] arr [0:3];
    always @(posedge clk) wb_rd_data <= arr[wb_rd_index];

    // Write responder: FIFO, then burst to wr_mem; done is a level that drops two cycles after go.
    logic [31:0] wr_mem [0:511];
    logic [31:0] wbuf [0:15];
    logic [3:0]  whead, wtail;
    logic        w_go_d, w_pend, full_force = 1'b0;
    logic [31:0] w_base_l;
    int          w_cnt;
    assign mem_write.control_done = !w_pend;
    assign mem_write.user_full    = full_force;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            whead <= '0; wtail <= '0; w_go_d <= 1'b0; w_pend <= 1'b0; w_cnt <= 0;
        end else begin
            if (mem_write.user_we && !mem_write.user_full) begin
                wbuf[wtail] <= mem_write.user_data;
                wtail <= wtail + 1'b1;
            end
            w_go_d <= mem_write.control_go;
            if (mem_write.control_go) w_base_l <= mem_write.control_base;
            if (w_go_d) begin
                w_pend <= 1'b1; w_cnt <= 0;
            end else if (w_pend) begin
                if (w_cnt == LW) w_pend <= 1'b0;
                else if (whead != wtail) begin
                    wr_mem[int'(w_base_l >> 2) + w_cnt] <= wbuf[whead];
                    whead <= whead + 1'b1;
                    w_cnt <= w_cnt + 1;
                end
            end
        end
    end

    // Read responder: streams rd_mem words into a show-ahead FIFO, done after rd_delay.
    logic [31:0] rd_mem [0:511];
    logic [31:0] rbuf [0:15];
    logic [3:0]  rhead, rtail;
    logic        r_go_d, r_pend, gate;
    logic [31:0] r_base_l;
    int          r_fed, r_wait;
    int          rd_delay = 3;
    logic        toggle_mode = 1'b0;
    assign mem_read.control_done   = !r_pend;
    assign mem_read.user_available = (rhead != rtail) && gate;
    assign mem_read.user_data      = rbuf[rhead];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rhead <= '0; rtail <= '0; r_go_d <= 1'b0; r_pend <= 1'b0;
            r_fed <= 0; r_wait <= 0; gate <= 1'b1;
        end else begin
            r_go_d <= mem_read.control_go;
            if (mem_read.control_go) r_base_l <= mem_read.control_base;
            if (r_go_d) begin
                r_pend <= 1'b1; r_fed <= 0; r_wait <= 0;
            end else if (r_pend) begin
                if (r_fed != LW) begin
                    rbuf[rtail] <= rd_mem[int'(r_base_l >> 2) + r_fed];
                    rtail <= rtail + 1'b1;
                    r_fed <= r_fed + 1;
                end else if (r_wait == rd_delay) r_pend <= 1'b0;
                else r_wait <= r_wait + 1;
            end
            if (mem_read.user_re) rhead <= rhead + 1'b1;
            gate <= toggle_mode ? !gate : 1'b1;
        end
    end

    // Scoreboard queues and monitor
    logic [31:0] exp_wgo[$], exp_rgo[$], exp_push[$];
    logic [33:0] exp_fill[$];
    int          exp_done = 0;
    int          wgo_seen = 0, fill_seen = 0, push_seen = 0, done_seen = 0;
    int          acc_cyc = 0, done_cyc = 0, rdone_cyc = 0;
    logic        first_push_pending = 1'b0, prev_rdone = 1'b1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_write.control_go) begin
                wgo_seen++;
                if (exp_wgo.size() == 0) fail("unexpected_write_go");
                else begin
                    chk("wgo_base", mem_write.control_base, exp_wgo.pop_front());
                    chk("wgo_len", mem_write.control_length, 16);
                end
            end
            if (mem_read.control_go) begin
                chk("wb_before_fill", exp_wgo.size(), 0);
                if (exp_rgo.size() == 0) fail("unexpected_read_go");
                else begin
                    chk("rgo_base", mem_read.control_base, exp_rgo.pop_front());
                    chk("rgo_len", mem_read.control_length, 16);
                end
            end
            if (mem_write.user_we) begin
                push_seen++;
                if (first_push_pending) begin
                    chk("accept_to_user_we", cyc - acc_cyc, 2);
                    first_push_pending = 1'b0;
                end
                if (exp_push.size() == 0) fail("unexpected_user_we");
                else chk("push_data", mem_write.user_data, exp_push.pop_front());
            end
            if (fill_we) begin
                fill_seen++;
                chk("fill_re_same_cycle", mem_read.user_re, 1);
                if (exp_fill.size() == 0) fail("unexpected_fill_we");
                else chk("fill_idx_data", {fill_index, fill_data}, exp_fill.pop_front());
            end
            if (done) begin
                done_seen++;
                done_cyc = cyc;
                if (exp_done == 0) fail("unexpected_done");
                else exp_done--;
            end
            if (mem_read.control_done && !prev_rdone) rdone_cyc = cyc;
            prev_rdone = mem_read.control_done;
        end
    end

    task automatic issue(input logic wb, input logic fill, input logic [31:0] wa, input logic [31:0] fa);
        @(posedge clk); #1;
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_wb = wb; req_fill = fill;
        req_wb_addr = wa; req_fill_addr = fa;
        acc_cyc = cyc;
        first_push_pending = wb;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int start = done_seen;
        int n = 0;
        while (done_seen == start && n < 400) begin
            @(posedge clk); n++;
        end
        if (done_seen == start) fail({name, "_timeout"});
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_done_once"}, done_seen - start, 1);
        chk({name, "_leftover"}, exp_wgo.size() + exp_rgo.size() + exp_push.size() + exp_fill.size() + exp_done, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_req_ready"}, req_ready, 1);
        chk({name, "_ctl"}, {done, fill_we, mem_write.user_we, mem_read.user_re,
                             mem_write.control_go, mem_read.control_go}, 0);
        chk({name, "_idx"}, {wb_rd_index, fill_index}, 0);
        chk({name, "_wbase_len"}, {mem_write.control_base, mem_write.control_length}, 0);
        chk({name, "_rbase_len"}, {mem_read.control_base, mem_read.control_length}, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, n;
        for (int i = 0; i < 512; i++) rd_mem[i] = 32'h0;
        for (int i = 0; i < 4; i++) arr[i] = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Writeback 0x100 then refill 0x200
        for (int i = 0; i < 4; i++) begin
            arr[i] = 32'hA000_0000 + i;
            rd_mem[(32'h200 >> 2) + i] = 32'hB000_0000 + i;
            exp_push.push_back(32'hA000_0000 + i);
            exp_fill.push_back({2'(i), 32'hB000_0000 + i});
        end
        exp_wgo.push_back(32'h100);
        exp_rgo.push_back(32'h200);
        exp_done++;
        issue(1'b1, 1'b1, 32'h100, 32'h200);
        wait_done("wb_fill");
        for (int i = 0; i < 4; i++) chk("wb_fill_mem", wr_mem[(32'h100 >> 2) + i], 32'hA000_0000 + i);

        // Fill only, unaligned address
        for (int i = 0; i < 4; i++) exp_fill.push_back({2'(i), 32'hB000_0000 + i});
        exp_rgo.push_back(32'h200);
        exp_done++;
        issue(1'b0, 1'b1, 32'h0, 32'h20C);
        wait_done("fill_unaligned");

        // Backpressure: user_full high 5 cycles mid-push
        for (int i = 0; i < 4; i++) begin
            arr[i] = 32'hC000_0000 + i;
            exp_push.push_back(32'hC000_0000 + i);
        end
        exp_wgo.push_back(32'h300);
        exp_done++;
        start = push_seen;
        issue(1'b1, 1'b0, 32'h300, 32'h0);
        n = 0;
        while (push_seen == start && n < 50) begin @(posedge clk); n++; end
        if (push_seen == start) fail("bp_first_push_timeout");
        #1 full_force = 1'b1;
        repeat (5) @(posedge clk);
        #1 full_force = 1'b0;
        wait_done("backpressure");
        chk("bp_push_count", push_seen - start, 4);
        for (int i = 0; i < 4; i++) chk("bp_mem", wr_mem[(32'h300 >> 2) + i], 32'hC000_0000 + i);

        // Read gaps: available toggles every cycle, control_done arrives late
        for (int i = 0; i < 4; i++) begin
            rd_mem[(32'h400 >> 2) + i] = 32'hD000_0000 + i;
            exp_fill.push_back({2'(i), 32'hD000_0000 + i});
        end
        exp_rgo.push_back(32'h400);
        exp_done++;
        toggle_mode = 1'b1;
        rd_delay = 12;
        issue(1'b0, 1'b1, 32'h0, 32'h400);
        wait_done("read_gaps");
        chk("done_after_ctrl_done", done_cyc - rdone_cyc, 1);

        // No-op command
        exp_done++;
        issue(1'b0, 1'b0, 32'h0, 32'h0);
        wait_done("noop");
        chk("noop_latency", done_cyc - acc_cyc, 1);

        // Busy rejection during WB_WAIT, then reset during RD_STREAM
        rd_delay = 40;
        for (int i = 0; i < 4; i++) begin
            arr[i] = 32'hE000_0000 + i;
            rd_mem[(32'h500 >> 2) + i] = 32'hF000_0000 + i;
            exp_push.push_back(32'hE000_0000 + i);
            exp_fill.push_back({2'(i), 32'hF000_0000 + i});
        end
        exp_wgo.push_back(32'h180);
        exp_rgo.push_back(32'h500);
        start = wgo_seen;
        issue(1'b1, 1'b1, 32'h180, 32'h500);
        n = 0;
        while (wgo_seen == start && n < 50) begin @(posedge clk); n++; end
        if (wgo_seen == start) fail("busy_wgo_timeout");
        #1;
        req_valid = 1'b1; req_wb = 1'b1; req_fill = 1'b1;
        req_wb_addr = 32'h700; req_fill_addr = 32'h740;
        chk("busy_req_ready", req_ready, 0);
        @(posedge clk); #1;
        chk("busy_req_ready2", req_ready, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        start = fill_seen;
        n = 0;
        while (fill_seen == start && n < 80) begin @(posedge clk); n++; end
        if (fill_seen == start) fail("stream_timeout");
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_wgo.delete(); exp_rgo.delete(); exp_push.delete(); exp_fill.delete();
        exp_done = 0;
        toggle_mode = 1'b0;
        rd_delay = 3;
        start = done_seen;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("no_done_after_reset", done_seen - start, 0);
        check_reset_outputs("post_reset_idle");

        // Recovery: no-op completes normally after reset
        exp_done++;
        issue(1'b0, 1'b0, 32'h0, 32'h0);
        wait_done("recover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
